csr_trap_ctrl: RTL
==================

# csr_trap_ctrl

Sequencer and write-port arbiter for the standard machine-mode CSR file. Owns the CSR write port and one read port, and runs trap entry and MRET as fixed multi-cycle sequences. Trap entry saves mepc and mcause, then fetches mtvec. MRET fetches mepc. Each sequence ends in a one-cycle pipeline flush with a redirect PC. Sits between the execute/exception logic and the CSR register file; pipeline CSR writes pass through it and are stalled while a sequence is running.

## Interface
Parameters:
- none (CSR addresses and state encodings come from the shared header)

Ports:
- `CLK`  in  1  — single clock, rising edge
- `RST_N`  in  1  — reset, asynchronous, active-low
- `TRAP_REQ`  in  1  — trap entry request; level, held until `ACK`
- `TRAP_CAUSE`  in  32  — mcause value; bit 31 = interrupt
- `TRAP_PC`  in  32  — PC to save in mepc
- `MRET_REQ`  in  1  — return request; level, held until `ACK`
- `ACK`  out  1  — one-cycle pulse: request accepted
- `BUSY`  out  1  — high whenever state != IDLE
- `PIPE_WREN`  in  1  — pipeline CSR write enable
- `PIPE_WADDR`  in  12  — pipeline CSR write address
- `PIPE_WDATA`  in  32  — pipeline CSR write data
- `PIPE_WAIT`  out  1  — pipeline write blocked; hold request
- `CSR_WREN`  out  1  — to CSR file
- `CSR_WADDR`  out  12  — to CSR file
- `CSR_WDATA`  out  32  — to CSR file
- `CSR_RADDR`  out  12  — to CSR file
- `CSR_RDATA`  in  32  — read data; valid the cycle after `CSR_RADDR` is presented
- `FLUSH`  out  1  — one-cycle pipeline flush
- `NEW_PC`  out  32  — redirect target; valid while `FLUSH` is high

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, RD_EPC, WAIT_EPC, JUMP.
- IDLE with `TRAP_REQ`=1:
  - latch cause and PC; go to SAVE_EPC; `ACK`=1 next cycle.
  - `TRAP_REQ` wins over a simultaneous `MRET_REQ`; MRET is not acked.
- IDLE with `MRET_REQ`=1 only: go to RD_EPC; `ACK`=1 next cycle.
- SAVE_EPC:
  - write 0x341 ← latched PC.
  - `CSR_RADDR`=0x305.
  - go to SAVE_CAUSE.
- SAVE_CAUSE:
  - write 0x342 ← latched cause.
  - latch `CSR_RDATA` as mtvec.
  - go to JUMP.
- RD_EPC: `CSR_RADDR`=0x341; go to WAIT_EPC.
- WAIT_EPC: latch `CSR_RDATA` as target; go to JUMP.
- JUMP:
  - `FLUSH`=1, `NEW_PC` = target.
  - trap target = {mtvec[31:2],2'b00}; MRET target = {mepc[31:1],1'b0}.
  - go to IDLE.
- Arbitration:
  - In IDLE the pipeline write passes straight through (combinational mux) and `PIPE_WAIT`=0.
  - In IDLE with `TRAP_REQ`=1, the pipeline write is suppressed (the faulting instruction must not commit) and `PIPE_WAIT`=1.
  - In any other state `PIPE_WAIT`=1 and the sequencer drives the port.
- Requests arriving outside IDLE are ignored until IDLE; requesters hold them.
- `CSR_RADDR`=0 and `CSR_WREN`=0 whenever the sequencer is not using the port.

## Timing
- Reset (async, `RST_N` low): state IDLE; all outputs 0; latched registers 0. Reset mid-sequence aborts it with no further CSR writes and no `FLUSH`.
- Trap with request sampled at edge N:
  - `ACK` and mepc write in cycle N+1.
  - mcause write in N+2.
  - `FLUSH` in N+3.
  - `BUSY` high in N+1..N+3.
- MRET with request sampled at edge N: `ACK` in N+1, `FLUSH` in N+3.
- Back-to-back: a request held through JUMP is sampled at the JUMP→IDLE edge and is accepted at the earliest on the edge after that, i.e. one IDLE cycle minimum.
- `ACK`, `FLUSH`, `BUSY`, `CSR_RADDR` and the sequencer write fields decode from registered state only.

## Configuration
- `CSR_TRAP_VECTORED_EN` defined:
  - if mtvec[1:0]==2'b01 and cause[31]==1, trap target = {mtvec[31:2],2'b00} + (cause[30:0]<<2), truncated to 32 bits.
  - exceptions and direct mode use the base address.
- Not defined: mtvec[1:0] are ignored and the target is always the base address.

## Structure
- Shared header `csr_defs.vh`:
  - CSR address constants (MTVEC 0x305, MSCRATCH 0x340, MEPC 0x341, MCAUSE 0x342).
  - state encodings for this block.
- Sub-module `csr_trap_vec`: combinational target-PC computation (base/vectored, masking). It holds the only macro-dependent logic.

## Test plan
- Trap: cause=0x0000000B, pc=0x80000100, mtvec=0x00001000 → writes 0x341←0x80000100 then 0x342←0x0000000B; `FLUSH` at N+3 with `NEW_PC`=0x00001000.
- MRET with mepc=0x80000104 → `ACK` at N+1, no CSR write, `FLUSH` at N+3 with `NEW_PC`=0x80000104.
- Simultaneous `TRAP_REQ`, `MRET_REQ`, and pipeline write 0x340←0x5 → trap sequence runs; mscratch unchanged; MRET acked only after `FLUSH`.
- Vectored (macro on): mtvec=0x00002001, cause=0x80000007 → `NEW_PC`=0x0000201C. Macro off, same stimulus → `NEW_PC`=0x00002000.
- Pipeline write 0x340←0xDEADBEEF during SAVE_EPC → `PIPE_WAIT`=1 until IDLE; the write lands on the first IDLE cycle.
- `RST_N` low during SAVE_CAUSE → `BUSY`, `FLUSH`, `CSR_WREN` drop immediately; no `FLUSH` after release.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl_pkg : CSR addresses, sequencer state encodings, write-port type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package csr_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SAVE_EPC   = 3'd1;
  localparam logic [2:0] ST_SAVE_CAUSE = 3'd2;
  localparam logic [2:0] ST_RD_EPC     = 3'd3;
  localparam logic [2:0] ST_WAIT_EPC   = 3'd4;
  localparam logic [2:0] ST_JUMP       = 3'd5;

  typedef struct packed {
    logic        en;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;

endpackage

`default_nettype wire

// File: rtl/csr_trap_vec.sv
// ---------------------------------------------------------------------------
// csr_trap_vec : redirect target for trap entry (base/vectored) and MRET
// Rev 1.0 -- vectored mode enabled by macro CSR_TRAP_VECTORED_EN
// ---------------------------------------------------------------------------
`default_nettype none

module csr_trap_vec (
  input  logic        is_trap_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] target_o
);

  logic [31:0] base;
  logic [31:0] trap_pc;

  assign base = {mtvec_i[31:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
  // Only interrupts vector; cause[30] falls off the top after the shift.
  logic unused_vec;
  assign unused_vec = cause_i[30] ^ epc_i[0];
  assign trap_pc = (mtvec_i[1:0] == 2'b01 && cause_i[31]) ?
                   base + {cause_i[29:0], 2'b00} : base;
`else
  logic unused_vec;
  assign unused_vec = ^{cause_i, mtvec_i[1:0], epc_i[0]};
  assign trap_pc = base;
`endif

  assign target_o = is_trap_i ? trap_pc : {epc_i[31:1], 1'b0};

endmodule

`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl : machine-mode trap/MRET sequencer and CSR write-port arbiter
// Rev 1.0 -- optional vectored traps via macro CSR_TRAP_VECTORED_EN
// ---------------------------------------------------------------------------
`default_nettype none

module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        TRAP_REQ,
  input  logic [31:0] TRAP_CAUSE,
  input  logic [31:0] TRAP_PC,
  input  logic        MRET_REQ,
  output logic        ACK,
  output logic        BUSY,
  input  logic        PIPE_WREN,
  input  logic [11:0] PIPE_WADDR,
  input  logic [31:0] PIPE_WDATA,
  output logic        PIPE_WAIT,
  output logic        CSR_WREN,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic [11:0] CSR_RADDR,
  input  logic [31:0] CSR_RDATA,
  output logic        FLUSH,
  output logic [31:0] NEW_PC
);

  logic [2:0]  state_q, state_d;
  logic        is_trap_q, is_trap_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target;
  logic        idle;
  logic        pipe_pass;
  csr_wr_t     seq_wr;
  csr_wr_t     port_wr;

  assign idle = (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    is_trap_d = is_trap_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    mtvec_d   = mtvec_q;
    epc_d     = epc_q;
    case (state_q)
      ST_IDLE: begin
        if (TRAP_REQ) begin
          state_d   = ST_SAVE_EPC;
          is_trap_d = 1'b1;
          pc_d      = TRAP_PC;
          cause_d   = TRAP_CAUSE;
        end else if (MRET_REQ) begin
          state_d   = ST_RD_EPC;
          is_trap_d = 1'b0;
        end
      end
      ST_SAVE_EPC:   state_d = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE: begin
        mtvec_d = CSR_RDATA;
        state_d = ST_JUMP;
      end
      ST_RD_EPC:     state_d = ST_WAIT_EPC;
      ST_WAIT_EPC: begin
        epc_d   = CSR_RDATA;
        state_d = ST_JUMP;
      end
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      is_trap_q <= 1'b0;
      pc_q      <= '0;
      cause_q   <= '0;
      mtvec_q   <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_trap_q <= is_trap_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      mtvec_q   <= mtvec_d;
      epc_q     <= epc_d;
    end
  end

  always_comb begin
    seq_wr    = '0;
    CSR_RADDR = '0;
    case (state_q)
      ST_SAVE_EPC: begin
        seq_wr    = csr_wr_t'{en: 1'b1, addr: CSR_MEPC, data: pc_q};
        CSR_RADDR = CSR_MTVEC;
      end
      ST_SAVE_CAUSE: seq_wr    = csr_wr_t'{en: 1'b1, addr: CSR_MCAUSE, data: cause_q};
      ST_RD_EPC:     CSR_RADDR = CSR_MEPC;
      default: ;
    endcase
  end

  // A trap request in IDLE blocks the faulting instruction's own CSR write.
  assign pipe_pass = idle && RST_N && !TRAP_REQ;
  assign port_wr   = pipe_pass ? csr_wr_t'{en: PIPE_WREN, addr: PIPE_WADDR, data: PIPE_WDATA}
                               : seq_wr;

  assign CSR_WREN  = port_wr.en;
  assign CSR_WADDR = port_wr.addr;
  assign CSR_WDATA = port_wr.data;
  assign PIPE_WAIT = RST_N && (!idle || TRAP_REQ);

  assign ACK   = (state_q == ST_SAVE_EPC) || (state_q == ST_RD_EPC);
  assign BUSY  = !idle;
  assign FLUSH = (state_q == ST_JUMP);

  csr_trap_vec u_vec (
    .is_trap_i (is_trap_q),
    .mtvec_i   (mtvec_q),
    .cause_i   (cause_q),
    .epc_i     (epc_q),
    .target_o  (target)
  );

  assign NEW_PC = FLUSH ? target : '0;

endmodule

`default_nettype wire
